// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store FSM with byte/halfword lane handling and read-modify-write sub-word stores.
// LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of having their low address bits forced to 0.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);
   typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;
   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, word_q;
   logic        illegal, misalign, fault;
   logic [1:0]  lane;
   logic [4:0]  sh;
   logic [31:0] byte_v, half_v, load_v, mask, merged;
   always_comb begin
      illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                       : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                 ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
`else
      misalign = 1'b0;
`endif
      fault = illegal | misalign;
      // lane bits are forced aligned; with trapping enabled misaligned requests never reach here
      lane = f3_q[1] ? 2'b00 : f3_q[0] ? {addr_q[1], 1'b0} : addr_q[1:0];
      sh = {lane, 3'b000};
      byte_v = mem_rd >> sh;
      half_v = mem_rd >> sh;
      load_v = f3_q[1] ? mem_rd
             : f3_q[0] ? {{16{half_v[15] & ~f3_q[2]}}, half_v[15:0]}
             : {{24{byte_v[7] & ~f3_q[2]}}, byte_v[7:0]};
      mask = f3_q[1] ? 32'hFFFF_FFFF : f3_q[0] ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
      merged = (word_q & ~mask) | ((wdata_q << sh) & mask);
   end
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign mem_we    = state == WRITE;
   assign mem_wd    = mem_we ? merged : 32'h0;
   assign mem_a     = (state == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         word_q    <= 32'h0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q      <= req_we;
               f3_q      <= req_funct3;
               addr_q    <= req_addr;
               wdata_q   <= req_wdata;
               rsp_rdata <= 32'h0;
               rsp_err   <= fault;
               state     <= fault ? RESP : !req_we ? LOAD : req_funct3[1] ? WRITE : READ;
            end
            LOAD: begin
               rsp_rdata <= load_v;
               state     <= RESP;
            end
            READ: begin
               word_q <= mem_rd;
               state  <= WRITE;
            end
            WRITE: state <= RESP;
            RESP: begin
               rsp_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a small word memory model.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
   logic [31:0] mem [16];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = 4'd0;
   logic [31:0] pre_val = 32'h0;
   int          total = 0, bad = 0;
   int          lat, nwe, nrsp;
   logic [31:0] rd, wa, wdv;
   logic        er, rdy1;

   load_store_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;
   assign mem_rd = mem[mem_a[3:0]];
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (mem_we) mem[mem_a[3:0]] <= mem_wd;
   end

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // sample k=1 is just after the accept edge; garbage on req_* afterwards must be ignored
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b011; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
      rdy1 = req_ready;
      lat = 0; nwe = 0; nrsp = 0; rd = 32'hx; er = 1'bx; wa = 32'hx; wdv = 32'hx;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (mem_we) begin nwe++; wa = mem_a; wdv = mem_wd; end
         if (rsp_valid) begin
            nrsp++;
            if (lat == 0) begin lat = k; rd = rsp_rdata; er = rsp_err; end
         end
      end
   endtask

   task automatic test_reset;
      #3;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
      total++; if (mem_wd !== 32'h0) begin bad++; $display("FAIL rst_mem_wd got=%h exp=0", mem_wd); end
      total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_sw;
      preload(4'd4, 32'h0);
      do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL sw_busy_ready got=%b exp=0", rdy1); end
      total++; if (nwe !== 1) begin bad++; $display("FAIL sw_we_cycles got=%0d exp=1", nwe); end
      total++; if (wa !== 32'h4) begin bad++; $display("FAIL sw_mem_a got=%h exp=4", wa); end
      total++; if (wdv !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem_wd got=%h exp=deadbeef", wdv); end
      total++; if (lat !== 2 || nrsp !== 1) begin bad++; $display("FAIL sw_latency got=%0d/%0d exp=2/1", lat, nrsp); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_rsp got=%b/%h exp=0/0", er, rd); end
      total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem4 got=%h exp=deadbeef", mem[4]); end
   endtask

   task automatic test_loads;
      logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
      logic [31:0] ad [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10};
      logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
      preload(4'd4, 32'h80FF7F01);
      for (int i = 0; i < 6; i++) begin
         do_access(1'b0, f3[i], ad[i], 32'hFFFF_FFFF);
         total++; if (rd !== ex[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, ex[i]); end
         total++; if (lat !== 2 || er !== 1'b0 || nwe !== 0) begin bad++; $display("FAIL load%0d_timing got lat=%0d err=%b we=%0d exp 2/0/0", i, lat, er, nwe); end
      end
      #2 rst = 1'b0;
      #1;
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL async_rst_rdata got=%h exp=0", rsp_rdata); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_sub_word_store;
      preload(4'd4, 32'h11223344);
      do_access(1'b1, 3'b000, 32'h11, 32'h123456AA);
      total++; if (wdv !== 32'h1122AA44 || nwe !== 1) begin bad++; $display("FAIL sb_mem_wd got=%h/%0d exp=1122aa44/1", wdv, nwe); end
      total++; if (lat !== 3 || er !== 1'b0) begin bad++; $display("FAIL sb_latency got=%0d/%b exp=3/0", lat, er); end
      do_access(1'b1, 3'b001, 32'h12, 32'hCAFEBEEF);
      total++; if (wdv !== 32'hBEEFAA44 || lat !== 3) begin bad++; $display("FAIL sh_mem_wd got=%h/%0d exp=beefaa44/3", wdv, lat); end
   endtask

   task automatic test_misalign;
      do_access(1'b0, 3'b010, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      total++; if (er !== 1'b1 || lat !== 1 || nwe !== 0 || rd !== 32'h0) begin bad++; $display("FAIL lw_misalign got err=%b lat=%0d we=%0d rd=%h exp 1/1/0/0", er, lat, nwe, rd); end
      do_access(1'b1, 3'b001, 32'h13, 32'h1234);
      total++; if (er !== 1'b1 || lat !== 1 || nwe !== 0) begin bad++; $display("FAIL sh_misalign got err=%b lat=%0d we=%0d exp 1/1/0", er, lat, nwe); end
      total++; if (mem[4] !== 32'hBEEFAA44) begin bad++; $display("FAIL sh_misalign_mem got=%h exp=beefaa44", mem[4]); end
`else
      total++; if (er !== 1'b0 || lat !== 2 || rd !== 32'hBEEFAA44) begin bad++; $display("FAIL lw_misalign got err=%b lat=%0d rd=%h exp 0/2/beefaa44", er, lat, rd); end
      do_access(1'b1, 3'b001, 32'h13, 32'h1234);
      total++; if (er !== 1'b0 || lat !== 3 || wdv !== 32'h1234AA44) begin bad++; $display("FAIL sh_misalign got err=%b lat=%0d wd=%h exp 0/3/1234aa44", er, lat, wdv); end
`endif
   endtask

   task automatic test_illegal;
      do_access(1'b0, 3'b111, 32'h10, 32'h0);
      total++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin bad++; $display("FAIL load_f3_111 got err=%b lat=%0d rd=%h exp 1/1/0", er, lat, rd); end
      do_access(1'b1, 3'b011, 32'h10, 32'h5555_5555);
      total++; if (er !== 1'b1 || lat !== 1 || nwe !== 0 || nrsp !== 1) begin bad++; $display("FAIL store_f3_011 got err=%b lat=%0d we=%0d rsp=%0d exp 1/1/0/1", er, lat, nwe, nrsp); end
   endtask

   task automatic test_reset_in_write;
      int seen;
      preload(4'd8, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rw_in_write got=%b exp=1", mem_we); end
      #2 rst = 1'b0;
      #1;
      total++; if (mem_we !== 1'b0 || mem_wd !== 32'h0 || mem_a !== 32'h0) begin bad++; $display("FAIL rw_abort got we=%b wd=%h a=%h exp 0/0/0", mem_we, mem_wd, mem_a); end
      seen = 0;
      for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL rw_no_rsp got=%0d exp=0", seen); end
      @(negedge clk); rst = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b exp=1", req_ready); end
      total++; if (mem[8] !== 32'h0) begin bad++; $display("FAIL rw_no_write got=%h exp=0", mem[8]); end
      do_access(1'b1, 3'b010, 32'h20, 32'h12345678);
      total++; if (lat !== 2 || nwe !== 1 || er !== 1'b0 || mem[8] !== 32'h12345678) begin bad++; $display("FAIL rw_resume got lat=%0d we=%0d err=%b mem=%h exp 2/1/0/12345678", lat, nwe, er, mem[8]); end
   endtask

   initial begin
      test_reset;
      test_sw;
      test_loads;
      test_sub_word_store;
      test_misalign;
      test_illegal;
      test_reset_in_write;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
